// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a fixed per-game note ROM, driving a one-hot
// note select and tone enable, with programmable note length and inter-note gap.
module melody_sequencer #(
  parameter int NOTE_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 1250000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] melody_id,
  output logic [6:0] SEL,
  output logic       enable,
  output logic       busy,
  output logic       done
);

  localparam int MAXC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;
  localparam int GAP_M1 = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_M1);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    id_q, id_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [6:0]    sel_q, sel_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Note ROM: element i of each row is the i-th note played.
  function automatic logic [2:0] rom_note(input logic [2:0] id, input logic [2:0] i);
    logic [7:0][2:0] row;
    case (id)
      3'd0:    row = {3'd0, 3'd0, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd2};
      3'd1:    row = {3'd6, 3'd6, 3'd6, 3'd6, 3'd2, 3'd4, 3'd2, 3'd2};
      3'd2:    row = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd4};
      3'd3:    row = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
      3'd4:    row = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd3, 3'd5};
      default: row = '0;
    endcase
    return row[i];
  endfunction

  function automatic logic [2:0] last_idx(input logic [2:0] id);
    case (id)
      3'd0:    return 3'd5;
      3'd1:    return 3'd7;
      3'd2:    return 3'd1;
      3'd3:    return 3'd1;
      3'd4:    return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    sel_d   = sel_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d  = '0;
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          if (melody_id <= 3'd4) begin
            state_d = PLAY;
            id_d    = melody_id;
            idx_d   = '0;
            timer_d = '0;
            sel_d   = 7'd1 << rom_note(melody_id, 3'd0);
            en_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      PLAY: begin
        if (timer_q == NOTE_LAST) begin
          timer_d = '0;
          if (idx_q == last_idx(id_q)) begin
            state_d = DONE;
            sel_d   = '0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (HAS_GAP) begin
            state_d = GAP;
            sel_d   = '0;
            en_d    = 1'b0;
          end else begin
            // No gap: identical consecutive notes merge into one tone.
            idx_d = idx_q + 3'd1;
            sel_d = 7'd1 << rom_note(id_q, idx_q + 3'd1);
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = PLAY;
          timer_d = '0;
          idx_d   = idx_q + 3'd1;
          sel_d   = 7'd1 << rom_note(id_q, idx_q + 3'd1);
          en_d    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        sel_d   = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SEL    = sel_q;
  assign enable = en_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
